// File: rtl/apb_reg_bridge_pkg.sv
// Shared types for the APB-to-register-space bridge: FSM states and APB response codes.
// No logic; imported by the bridge top.
// No backpressure concerns.
package apb_reg_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_ACK,
    WR_REQ,
    RESP
  } state_t;

  localparam logic OKAY   = 1'b0;
  localparam logic SLVERR = 1'b1;

endpackage

// File: rtl/apb_reg_bridge_if.sv
// APB slave port plus register-space read-request, read-ack and write-request channels.
// Pure wiring, zero latency.
// Backpressure is carried by the rreq_rdy / rack_vld / wreq_rdy handshakes.
interface apb_reg_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [2:0]            p_prot;
  logic                  p_sel;
  logic                  p_enable;
  logic                  p_write;
  logic [DATA_WIDTH-1:0] p_wdata;
  logic [STRB_WIDTH-1:0] p_strb;
  logic                  p_ready;
  logic [DATA_WIDTH-1:0] p_rdata;
  logic                  p_slverr;

  logic [ADDR_WIDTH-1:0] rreq_addr;
  logic                  rreq_vld;
  logic                  rreq_rdy;
  logic [DATA_WIDTH-1:0] rack_data;
  logic                  rack_vld;
  logic                  rack_rdy;
  logic [ADDR_WIDTH-1:0] wreq_addr;
  logic [DATA_WIDTH-1:0] wreq_data;
  logic [STRB_WIDTH-1:0] wreq_strb;
  logic                  wreq_vld;
  logic                  wreq_rdy;

  // Bridge side.
  modport slave (
    input  p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
    output p_ready, p_rdata, p_slverr,
    output rreq_addr, rreq_vld,
    input  rreq_rdy,
    input  rack_data, rack_vld,
    output rack_rdy,
    output wreq_addr, wreq_data, wreq_strb, wreq_vld,
    input  wreq_rdy
  );

  // APB master and register-space side.
  modport master (
    output p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
    input  p_ready, p_rdata, p_slverr,
    input  rreq_addr, rreq_vld,
    output rreq_rdy,
    output rack_data, rack_vld,
    input  rack_rdy,
    input  wreq_addr, wreq_data, wreq_strb, wreq_vld,
    output wreq_rdy
  );

endinterface

// File: rtl/apb_reg_bridge_timeout.sv
// Wait-cycle counter for the bridge; expired flags the TIMEOUT_CYCLES-th wait cycle.
// Combinational expired from a registered count.
// No handshake; clr/en come from the bridge FSM.
module apb_reg_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt;

  // cnt holds completed wait cycles, so the current one is cnt+1.
  assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB3/4 slave to register-space valid/ready bridge; APB_REG_BRIDGE_TIMEOUT_EN adds a PSLVERR timeout.
// Latency: read T3, write T2, zero-strobe write T1 after setup; +1 per stalled cycle.
// Inserts APB wait states until the downstream handshake completes (or times out).
module apb_reg_bridge
  import apb_reg_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             rst_n,
  apb_reg_bridge_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0) begin : g_bad_param
    $error("apb_reg_bridge: invalid TIMEOUT_CYCLES or DATA_WIDTH");
  end

  state_t state, next_state;

  logic                  setup;
  logic                  rd_done;
  logic                  err_set;
  logic                  timed_out;
  logic [DATA_WIDTH-1:0] wdata_masked;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  rreq_vld_q, rack_rdy_q, wreq_vld_q;
  logic                  p_ready_q, p_slverr_q;
  logic [DATA_WIDTH-1:0] p_rdata_q;

  assign setup = bus.p_sel && !bus.p_enable;

  always_comb begin
    wdata_masked = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (bus.p_strb[i]) wdata_masked[8*i +: 8] = bus.p_wdata[8*i +: 8];
    end
  end

`ifdef APB_REG_BRIDGE_TIMEOUT_EN
  apb_reg_bridge_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == IDLE),
    .en      (state == RD_REQ || state == RD_ACK || state == WR_REQ),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Handshake checks precede the timeout so a same-cycle completion wins.
  always_comb begin
    next_state = state;
    rd_done    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          if (!bus.p_write)     next_state = RD_REQ;
          else if (|bus.p_strb) next_state = WR_REQ;
          else                  next_state = RESP;
        end
      end
      RD_REQ: begin
        if (bus.rreq_rdy)   next_state = RD_ACK;
        else if (timed_out) begin next_state = RESP; err_set = 1'b1; end
      end
      RD_ACK: begin
        if (bus.rack_vld)   begin next_state = RESP; rd_done = 1'b1; end
        else if (timed_out) begin next_state = RESP; err_set = 1'b1; end
      end
      WR_REQ: begin
        if (bus.wreq_rdy)   next_state = RESP;
        else if (timed_out) begin next_state = RESP; err_set = 1'b1; end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (state == IDLE && setup) begin
      addr_q  <= bus.p_addr;
      wdata_q <= wdata_masked;
      strb_q  <= bus.p_strb;
    end
  end

  // Outputs are decoded from next_state so they are flops aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rreq_vld_q <= 1'b0;
      rack_rdy_q <= 1'b0;
      wreq_vld_q <= 1'b0;
      p_ready_q  <= 1'b0;
      p_rdata_q  <= '0;
      p_slverr_q <= OKAY;
    end else begin
      rreq_vld_q <= (next_state == RD_REQ);
      rack_rdy_q <= (next_state == RD_ACK);
      wreq_vld_q <= (next_state == WR_REQ);
      p_ready_q  <= (next_state == RESP);
      p_rdata_q  <= rd_done ? bus.rack_data : '0;
      p_slverr_q <= err_set ? SLVERR : OKAY;
    end
  end

  assign bus.rreq_addr = addr_q;
  assign bus.rreq_vld  = rreq_vld_q;
  assign bus.rack_rdy  = rack_rdy_q;
  assign bus.wreq_addr = addr_q;
  assign bus.wreq_data = wdata_q;
  assign bus.wreq_strb = strb_q;
  assign bus.wreq_vld  = wreq_vld_q;
  assign bus.p_ready   = p_ready_q;
  assign bus.p_rdata   = p_rdata_q;
  assign bus.p_slverr  = p_slverr_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Scoreboard bench for apb_reg_bridge: directed APB transfers, stall-configurable register-space responder.
module tb_apb_reg_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_reg_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  apb_reg_bridge #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        slverr;
  } rsp_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  rsp_t        exp_rsp[$];
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          rreq_stall = 0;
  int          rack_stall = 0;
  int          wreq_stall = 0;
  logic [31:0] rack_value = 32'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register-space responder: drives readies/acks after the configured stall.
  initial begin
    int rq_w, ak_w, wq_w;
    rq_w = 0; ak_w = 0; wq_w = 0;
    bus.rreq_rdy  = 1'b0;
    bus.rack_vld  = 1'b0;
    bus.rack_data = 32'h0;
    bus.wreq_rdy  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.rreq_rdy = 1'b0; bus.rack_vld = 1'b0; bus.wreq_rdy = 1'b0;
        rq_w = 0; ak_w = 0; wq_w = 0;
      end else begin
        if (bus.rreq_vld) begin
          if (rq_w < rreq_stall) begin bus.rreq_rdy = 1'b0; rq_w++; end
          else bus.rreq_rdy = 1'b1;
        end else begin
          bus.rreq_rdy = 1'b0; rq_w = 0;
        end
        if (bus.rack_rdy) begin
          if (ak_w < rack_stall) begin bus.rack_vld = 1'b0; ak_w++; end
          else begin bus.rack_vld = 1'b1; bus.rack_data = rack_value; end
        end else begin
          bus.rack_vld = 1'b0; ak_w = 0;
        end
        if (bus.wreq_vld) begin
          if (wq_w < wreq_stall) begin bus.wreq_rdy = 1'b0; wq_w++; end
          else bus.wreq_rdy = 1'b1;
        end else begin
          bus.wreq_rdy = 1'b0; wq_w = 0;
        end
      end
    end
  end

  // Monitor: compares every DUT output event against the scoreboard queues.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.p_ready) begin
          if (exp_rsp.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_p_ready at cycle %0d", cyc);
          end else begin
            r = exp_rsp.pop_front();
            chk("p_ready_cycle", cyc, r.cyc);
            chk("p_rdata", bus.p_rdata, r.rdata);
            chk("p_slverr", bus.p_slverr, r.slverr);
            chk("no_req_in_resp", {bus.rreq_vld, bus.rack_rdy, bus.wreq_vld}, 3'b000);
          end
        end else begin
          chk("idle_rsp_zero", {bus.p_slverr, bus.p_rdata}, 33'h0);
        end
        if (bus.rreq_vld) begin
          if (exp_rd.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_rreq addr %0h", bus.rreq_addr);
          end else begin
            chk("rreq_addr", bus.rreq_addr, exp_rd[0]);
            if (bus.rreq_rdy) void'(exp_rd.pop_front());
          end
        end
        if (bus.wreq_vld) begin
          if (exp_wr.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_wreq addr %0h", bus.wreq_addr);
          end else begin
            chk("wreq_addr", bus.wreq_addr, exp_wr[0].addr);
            chk("wreq_data", bus.wreq_data, exp_wr[0].data);
            chk("wreq_strb", bus.wreq_strb, exp_wr[0].strb);
            if (bus.wreq_rdy) void'(exp_wr.pop_front());
          end
        end
      end
    end
  end

  task automatic apb_start(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int lat,
                           input logic [31:0] exp_rdata, input logic exp_err);
    rsp_t r;
    @(posedge clk); #1;
    bus.p_sel    = 1'b1;
    bus.p_enable = 1'b0;
    bus.p_write  = wr;
    bus.p_addr   = addr;
    bus.p_wdata  = wdata;
    bus.p_strb   = strb;
    bus.p_prot   = 3'b010;
    r.cyc = cyc + lat; r.rdata = exp_rdata; r.slverr = exp_err;
    exp_rsp.push_back(r);
    @(posedge clk); #1;
    bus.p_enable = 1'b1;
  endtask

  task automatic apb_finish();
    int n;
    n = 0;
    while (!bus.p_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.p_ready) begin
      n_checks++; n_errors++;
      $display("FAIL p_ready_wait: got no p_ready within 60 cycles");
      exp_rsp.delete();
    end
    @(posedge clk); #1;
    bus.p_sel    = 1'b0;
    bus.p_enable = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [31:0] data, input int lat);
    exp_rd.push_back(addr);
    rack_value = data;
    apb_start(1'b0, addr, 32'hFFFF_FFFF, 4'hF, lat, data, 1'b0);
    apb_finish();
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_data, input int lat, input logic exp_err);
    wr_t w;
    if (strb != 4'h0) begin
      w.addr = addr; w.data = exp_data; w.strb = strb;
      exp_wr.push_back(w);
    end
    apb_start(1'b1, addr, wdata, strb, lat, 32'h0, exp_err);
    apb_finish();
  endtask

  initial begin
    int n;
    bus.p_sel = 1'b0; bus.p_enable = 1'b0; bus.p_write = 1'b0;
    bus.p_addr = 16'h0; bus.p_wdata = 32'h0; bus.p_strb = 4'h0; bus.p_prot = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {bus.p_ready, bus.p_rdata, bus.p_slverr, bus.rreq_vld, bus.rack_rdy, bus.wreq_vld,
         bus.rreq_addr, bus.wreq_addr, bus.wreq_data, bus.wreq_strb}, 128'h0);
    rst_n = 1'b1;

    do_read(16'h0010, 32'hA5A5_0001, 3);
    do_write(16'h0020, 32'h1122_3344, 4'b0101, 32'h0022_0044, 2, 1'b0);
    do_write(16'h0024, 32'hCAFE_F00D, 4'b0000, 32'h0, 1, 1'b0);
    do_write(16'h0028, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 2, 1'b0);
    do_write(16'h002C, 32'hAABB_CCDD, 4'b1000, 32'hAA00_0000, 2, 1'b0);

    rreq_stall = 5; rack_stall = 3;
    do_read(16'h0100, 32'h1234_5678, 11);
    rreq_stall = 0; rack_stall = 0;

    wreq_stall = 2;
    do_write(16'h0104, 32'h0102_0304, 4'b0011, 32'h0000_0304, 4, 1'b0);

`ifdef APB_REG_BRIDGE_TIMEOUT_EN
    wreq_stall = 1000;
    do_write(16'h0030, 32'h5566_7788, 4'b1111, 32'h5566_7788, 9, 1'b1);
    exp_wr.delete();
`else
    wreq_stall = 20;
    do_write(16'h0030, 32'h5566_7788, 4'b1111, 32'h5566_7788, 22, 1'b0);
`endif
    wreq_stall = 0;

    // Reset while the bridge waits in RD_ACK.
    rack_stall = 1000;
    exp_rd.push_back(16'h0040);
    rack_value = 32'h0BAD_0BAD;
    apb_start(1'b0, 16'h0040, 32'h0, 4'hF, 3, 32'h0BAD_0BAD, 1'b0);
    n = 0;
    while (!bus.rack_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_rd_ack", bus.rack_rdy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rack_rdy", bus.rack_rdy, 1'b0);
    chk("rst_mid_p_ready", bus.p_ready, 1'b0);
    chk("rst_mid_valids", {bus.rreq_vld, bus.wreq_vld}, 2'b00);
    exp_rsp.delete();
    bus.p_sel = 1'b0; bus.p_enable = 1'b0;
    rack_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_read(16'h0044, 32'hDEAD_BEEF, 3);

    repeat (4) @(posedge clk);
    #1;
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
